// File: rtl/dma_wr_splitter.sv
// dma_wr_splitter
// Accepts one DMA write command of any 64 B-multiple length and re-issues it
// as a sequence of sub-commands that never cross a MAX_LEN-aligned boundary.
// The 512-bit data stream is forwarded combinationally and m_data_last is
// regenerated at every sub-command boundary.
// Optional feature: define DMA_SPLIT_STATS_EN to implement the stat_chunks /
// stat_errors counters; without it both ports are tied to zero.
module dma_wr_splitter #(
    parameter int unsigned MAX_LEN = 4096
) (
    input  logic         pcie_clk,
    input  logic         pcie_rst,
    input  logic         s_cmd_valid,
    output logic         s_cmd_ready,
    input  logic [63:0]  s_cmd_address,
    input  logic [31:0]  s_cmd_length,
    output logic         m_cmd_valid,
    input  logic         m_cmd_ready,
    output logic [63:0]  m_cmd_address,
    output logic [31:0]  m_cmd_length,
    input  logic         s_data_valid,
    output logic         s_data_ready,
    input  logic [511:0] s_data_data,
    input  logic [63:0]  s_data_keep,
    input  logic         s_data_last,
    output logic         m_data_valid,
    input  logic         m_data_ready,
    output logic [511:0] m_data_data,
    output logic [63:0]  m_data_keep,
    output logic         m_data_last,
    output logic [31:0]  stat_chunks,
    output logic [31:0]  stat_errors
);

    localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);
    localparam logic [31:0] OFS_MASK  = MAX_LEN_W - 32'd1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CMD,
        DATA
    } state_t;

    state_t state;
    state_t next_state;

    logic [63:0] cur_addr;
    logic [31:0] rem;
    logic [31:0] beat_cnt;

    logic [31:0] room;
    logic [31:0] chunk;
    logic [31:0] beats;
    logic        last_beat;
    logic        final_beat;
    logic        s_cmd_hs;
    logic        cmd_hs;
    logic        data_hs;
    logic        zero_len_err;
    logic        data_err;

    // Distance to the next boundary is never zero, so every chunk holds at
    // least one beat and beats-1 cannot underflow.
    assign room       = MAX_LEN_W - (cur_addr[31:0] & OFS_MASK);
    assign chunk      = (rem < room) ? rem : room;
    assign beats      = {6'd0, m_cmd_length[31:6]};
    assign last_beat  = (beat_cnt == beats - 32'd1);
    assign final_beat = last_beat && (rem == 32'd0);

    assign s_cmd_hs     = s_cmd_valid && s_cmd_ready;
    assign cmd_hs       = m_cmd_valid && m_cmd_ready;
    assign data_hs      = m_data_valid && m_data_ready;
    assign zero_len_err = s_cmd_hs && (s_cmd_length == 32'd0);
    assign data_err     = data_hs && (s_data_last != final_beat);

    assign m_data_data = s_data_data;
    assign m_data_keep = s_data_keep;

    // State register.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs; data is only passed in DATA.
    always_comb begin
        next_state   = state;
        s_cmd_ready  = 1'b0;
        m_cmd_valid  = 1'b0;
        s_data_ready = 1'b0;
        m_data_valid = 1'b0;
        m_data_last  = 1'b0;
        case (state)
            IDLE: begin
                s_cmd_ready = !pcie_rst;
                if (s_cmd_valid && !pcie_rst && (s_cmd_length != 32'd0)) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                next_state = CMD;
            end
            CMD: begin
                m_cmd_valid = 1'b1;
                if (m_cmd_ready) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                m_data_valid = s_data_valid;
                s_data_ready = m_data_ready;
                m_data_last  = last_beat && s_data_valid;
                if (s_data_valid && m_data_ready && last_beat) begin
                    next_state = (rem == 32'd0) ? IDLE : CALC;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address/length bookkeeping: latch the command, size each chunk, and
    // advance once the chunk has been handed to the engine.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            cur_addr      <= 64'd0;
            rem           <= 32'd0;
            beat_cnt      <= 32'd0;
            m_cmd_address <= 64'd0;
            m_cmd_length  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_cmd_hs) begin
                        cur_addr <= s_cmd_address;
                        rem      <= s_cmd_length;
                    end
                end
                CALC: begin
                    m_cmd_address <= cur_addr;
                    m_cmd_length  <= chunk;
                end
                CMD: begin
                    if (cmd_hs) begin
                        cur_addr <= cur_addr + {32'd0, m_cmd_length};
                        rem      <= rem - m_cmd_length;
                        beat_cnt <= 32'd0;
                    end
                end
                DATA: begin
                    if (data_hs) begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end
                default: begin
                    cur_addr <= cur_addr;
                end
            endcase
        end
    end

`ifdef DMA_SPLIT_STATS_EN
    // Statistics: chunks issued and protocol errors, both free-running.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            stat_chunks <= 32'd0;
            stat_errors <= 32'd0;
        end else begin
            if (cmd_hs) begin
                stat_chunks <= stat_chunks + 32'd1;
            end
            if (zero_len_err || data_err) begin
                stat_errors <= stat_errors + 32'd1;
            end
        end
    end
`else
    logic unused_stats;

    assign stat_chunks  = 32'h0;
    assign stat_errors  = 32'h0;
    assign unused_stats = ^{zero_len_err, data_err};
`endif

endmodule

// File: tb/tb_dma_wr_splitter.sv
// tb_dma_wr_splitter
// Self-checking bench for dma_wr_splitter: directed scenarios plus randomized
// commands checked against a boundary-splitting reference model.
// Honours DMA_SPLIT_STATS_EN for the expected statistics values.
module tb_dma_wr_splitter;

    localparam int unsigned MAX_LEN = 4096;
`ifdef DMA_SPLIT_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic         pcie_clk = 1'b0;
    logic         pcie_rst;
    logic         s_cmd_valid;
    logic         s_cmd_ready;
    logic [63:0]  s_cmd_address;
    logic [31:0]  s_cmd_length;
    logic         m_cmd_valid;
    logic         m_cmd_ready;
    logic [63:0]  m_cmd_address;
    logic [31:0]  m_cmd_length;
    logic         s_data_valid;
    logic         s_data_ready;
    logic [511:0] s_data_data;
    logic [63:0]  s_data_keep;
    logic         s_data_last;
    logic         m_data_valid;
    logic         m_data_ready;
    logic [511:0] m_data_data;
    logic [63:0]  m_data_keep;
    logic         m_data_last;
    logic [31:0]  stat_chunks;
    logic [31:0]  stat_errors;

    dma_wr_splitter #(.MAX_LEN(MAX_LEN)) dut (
        .pcie_clk      (pcie_clk),
        .pcie_rst      (pcie_rst),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .s_cmd_address (s_cmd_address),
        .s_cmd_length  (s_cmd_length),
        .m_cmd_valid   (m_cmd_valid),
        .m_cmd_ready   (m_cmd_ready),
        .m_cmd_address (m_cmd_address),
        .m_cmd_length  (m_cmd_length),
        .s_data_valid  (s_data_valid),
        .s_data_ready  (s_data_ready),
        .s_data_data   (s_data_data),
        .s_data_keep   (s_data_keep),
        .s_data_last   (s_data_last),
        .m_data_valid  (m_data_valid),
        .m_data_ready  (m_data_ready),
        .m_data_data   (m_data_data),
        .m_data_keep   (m_data_keep),
        .m_data_last   (m_data_last),
        .stat_chunks   (stat_chunks),
        .stat_errors   (stat_errors)
    );

    // 100 MHz clock.
    always #5 pcie_clk = ~pcie_clk;

    int checks = 0;
    int errors = 0;

    logic [511:0] up_data[$];
    logic [63:0]  up_keep[$];
    bit           up_last[$];

    logic [63:0]  obs_addr[$];
    logic [31:0]  obs_len[$];
    int           obs_rise[$];
    int           obs_wait[$];
    logic [511:0] obs_data[$];
    logic [63:0]  obs_keep[$];
    bit           obs_last[$];
    int           obs_last_cyc[$];
    int           scmd_cyc;
    int           cmd_unstable;
    int           pass_err;
    int           stray_last;
    bit           timeout;

    logic [63:0]  exp_addr[$];
    logic [31:0]  exp_len[$];
    bit           exp_last[$];
    int unsigned  exp_chunks;
    int unsigned  exp_errors;

    // Global time limit so the bench always ends.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: cut [addr, addr+len) at every MAX_LEN boundary and
    // account for the statistics the command should produce.
    task automatic model_split(input logic [63:0] addr, input logic [31:0] len);
        logic [63:0] a;
        longint unsigned r;
        longint unsigned room;
        longint unsigned c;
        int total;
        exp_addr.delete();
        exp_len.delete();
        exp_last.delete();
        a = addr;
        r = len;
        while (r > 0) begin
            room = MAX_LEN - (a % MAX_LEN);
            c = (r < room) ? r : room;
            exp_addr.push_back(a);
            exp_len.push_back(32'(c));
            for (longint unsigned b = 0; b < c / 64; b++) exp_last.push_back(b == c / 64 - 1);
            a = a + c;
            r = r - c;
        end
        exp_chunks += exp_addr.size();
        total = int'(len / 64);
        if (len == 0) exp_errors += 1;
        for (int i = 0; i < total; i++) if (up_last[i] != (i == total - 1)) exp_errors += 1;
    endtask

    task automatic fill_stream(input int n, input bit counter);
        logic [511:0] d;
        up_data.delete();
        up_keep.delete();
        up_last.delete();
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = counter ? 32'(i) : $urandom;
            up_data.push_back(d);
            up_keep.push_back(counter ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom});
            up_last.push_back(i == n - 1);
        end
    endtask

    task automatic idle_inputs();
        s_cmd_valid  = 1'b0;
        s_data_valid = 1'b0;
        s_data_last  = 1'b0;
        m_cmd_ready  = 1'b0;
        m_data_ready = 1'b0;
    endtask

    // Drives one command and its upstream stream, recording what appears on
    // the master side. Inputs change on the falling edge, sampling follows 1 ns later.
    task automatic run_cmd(input logic [63:0] addr, input logic [31:0] len, input int cmd_hold,
                           input int rdy_pct, input int vld_pct);
        int total, up_idx, hold_left, settle, wait_cnt;
        bit cmd_done, up_hold, prev_valid;
        logic [63:0] hold_addr;
        logic [31:0] hold_len;
        obs_addr.delete(); obs_len.delete(); obs_rise.delete(); obs_wait.delete();
        obs_data.delete(); obs_keep.delete(); obs_last.delete(); obs_last_cyc.delete();
        scmd_cyc = -1; cmd_unstable = 0; pass_err = 0; stray_last = 0; timeout = 1'b1;
        total = int'(len >> 6);
        up_idx = 0; hold_left = cmd_hold; settle = 0; wait_cnt = 0;
        cmd_done = 1'b0; up_hold = 1'b0; prev_valid = 1'b0; hold_addr = '0; hold_len = '0;
        s_data_valid = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge pcie_clk);
            s_cmd_valid   = !cmd_done;
            s_cmd_address = addr;
            s_cmd_length  = len;
            if (up_idx < total) begin
                if (!up_hold) s_data_valid = ($urandom_range(99) < vld_pct);
                s_data_data = up_data[up_idx];
                s_data_keep = up_keep[up_idx];
                s_data_last = up_last[up_idx];
            end else begin
                s_data_valid = 1'b0;
            end
            m_data_ready = ($urandom_range(99) < rdy_pct);
            m_cmd_ready  = (hold_left == 0);
            #1;
            if (s_cmd_valid && s_cmd_ready) begin
                cmd_done = 1'b1;
                scmd_cyc = cyc;
            end
            if (m_cmd_valid) begin
                if (!prev_valid) begin
                    obs_rise.push_back(cyc);
                    wait_cnt = 0;
                end else if (m_cmd_address !== hold_addr || m_cmd_length !== hold_len) begin
                    cmd_unstable++;
                end
                hold_addr = m_cmd_address;
                hold_len  = m_cmd_length;
                if (m_cmd_ready) begin
                    obs_addr.push_back(m_cmd_address);
                    obs_len.push_back(m_cmd_length);
                    obs_wait.push_back(wait_cnt);
                    prev_valid = 1'b0;
                    hold_left  = cmd_hold;
                end else begin
                    prev_valid = 1'b1;
                    wait_cnt++;
                    if (hold_left > 0) hold_left--;
                end
            end else begin
                if (prev_valid) cmd_unstable++;
                prev_valid = 1'b0;
            end
            if (m_data_valid && (m_data_data !== s_data_data || m_data_keep !== s_data_keep || !s_data_valid))
                pass_err++;
            if ((s_data_valid && s_data_ready) !== (m_data_valid && m_data_ready)) pass_err++;
            if (m_data_last && !m_data_valid) stray_last++;
            if (m_data_valid && m_data_ready) begin
                obs_data.push_back(m_data_data);
                obs_keep.push_back(m_data_keep);
                obs_last.push_back(m_data_last);
                if (m_data_last) obs_last_cyc.push_back(cyc);
            end
            if (s_data_valid && s_data_ready) begin
                up_idx++;
                up_hold = 1'b0;
            end else begin
                up_hold = s_data_valid;
            end
            if (cmd_done && up_idx >= total) settle++;
            if (settle == 6) begin
                timeout = 1'b0;
                break;
            end
        end
        @(negedge pcie_clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        pcie_rst = 1'b1;
        idle_inputs();
        s_cmd_address = '0; s_cmd_length = '0; s_data_data = '0; s_data_keep = '0;
        repeat (3) @(negedge pcie_clk);
        #1;
        checks++;
        if ({s_cmd_ready, m_cmd_valid, m_data_valid, m_data_last, s_data_ready} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 00000",
                     {s_cmd_ready, m_cmd_valid, m_data_valid, m_data_last, s_data_ready});
        end
        checks++;
        if ({m_cmd_address, m_cmd_length, stat_chunks, stat_errors} !== 160'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got addr %0h len %0h chunks %0d errs %0d, expected all 0",
                     m_cmd_address, m_cmd_length, stat_chunks, stat_errors);
        end
        @(negedge pcie_clk);
        pcie_rst = 1'b0;
        #1;
        checks++;
        if (s_cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b, expected 1", s_cmd_ready);
        end
        exp_chunks = 0;
        exp_errors = 0;
    endtask

    task automatic test_aligned();
        fill_stream(64, 1'b0);
        run_cmd(64'h1000, 32'd4096, 0, 100, 100);
        exp_chunks += 1;
        checks++;
        if (timeout || obs_addr.size() != 1 || obs_data.size() != 64) begin
            errors++;
            $display("[TB] FAIL aligned_counts: got timeout %0d cmds %0d beats %0d, expected 0/1/64",
                     timeout, obs_addr.size(), obs_data.size());
        end
        checks++;
        if (obs_addr.size() > 0 && (obs_addr[0] !== 64'h1000 || obs_len[0] !== 32'd4096)) begin
            errors++;
            $display("[TB] FAIL aligned_cmd: got (%0h,%0d), expected (1000,4096)", obs_addr[0], obs_len[0]);
        end
        for (int i = 0; i < obs_data.size() && i < 64; i++) begin
            checks++;
            if (obs_last[i] !== (i == 63) || obs_data[i] !== up_data[i] || obs_keep[i] !== up_keep[i]) begin
                errors++;
                $display("[TB] FAIL aligned_beat%0d: got last %0d, expected last %0d (data match %0d)",
                         i, obs_last[i], (i == 63), obs_data[i] === up_data[i]);
            end
        end
        checks++;
        if (obs_rise.size() < 1 || obs_rise[0] != scmd_cyc + 2) begin
            errors++;
            $display("[TB] FAIL aligned_latency: got rise cycle %0d, expected %0d",
                     obs_rise.size() ? obs_rise[0] : -1, scmd_cyc + 2);
        end
        checks++;
        if (stat_chunks !== (STATS_ON ? exp_chunks : 0) || stat_errors !== (STATS_ON ? exp_errors : 0)) begin
            errors++;
            $display("[TB] FAIL aligned_stats: got %0d/%0d, expected %0d/%0d", stat_chunks, stat_errors,
                     STATS_ON ? exp_chunks : 0, STATS_ON ? exp_errors : 0);
        end
    endtask

    task automatic test_unaligned();
        logic [63:0] ea[3];
        int el[3];
        int lb[3];
        ea = '{64'h1_0000_0F00, 64'h1_0000_1000, 64'h1_0000_2000};
        el = '{256, 4096, 3840};
        lb = '{3, 67, 127};
        fill_stream(128, 1'b1);
        run_cmd(64'h1_0000_0F00, 32'd8192, 1, 60, 60);
        exp_chunks += 3;
        checks++;
        if (timeout || obs_addr.size() != 3 || obs_data.size() != 128 || pass_err != 0 || stray_last != 0) begin
            errors++;
            $display("[TB] FAIL unaligned_counts: got to %0d cmds %0d beats %0d pass %0d stray %0d, expected 0/3/128/0/0",
                     timeout, obs_addr.size(), obs_data.size(), pass_err, stray_last);
        end
        for (int k = 0; k < 3 && k < obs_addr.size(); k++) begin
            checks++;
            if (obs_addr[k] !== ea[k] || obs_len[k] !== 32'(el[k])) begin
                errors++;
                $display("[TB] FAIL unaligned_cmd%0d: got (%0h,%0d), expected (%0h,%0d)",
                         k, obs_addr[k], obs_len[k], ea[k], el[k]);
            end
        end
        for (int i = 0; i < obs_data.size() && i < 128; i++) begin
            checks++;
            if (obs_data[i] !== {16{32'(i)}} || obs_last[i] !== (i == lb[0] || i == lb[1] || i == lb[2])) begin
                errors++;
                $display("[TB] FAIL unaligned_beat%0d: got word0 %0h last %0d, expected word0 %0h last %0d",
                         i, obs_data[i][31:0], obs_last[i], i, (i == lb[0] || i == lb[1] || i == lb[2]));
            end
        end
        for (int k = 1; k < obs_rise.size() && k - 1 < obs_last_cyc.size(); k++) begin
            checks++;
            if (obs_rise[k] != obs_last_cyc[k-1] + 2) begin
                errors++;
                $display("[TB] FAIL unaligned_gap%0d: got rise %0d, expected %0d", k, obs_rise[k], obs_last_cyc[k-1] + 2);
            end
        end
    endtask

    task automatic test_boundary();
        fill_stream(96, 1'b0);
        run_cmd(64'h5800, 32'd6144, 0, 100, 100);
        exp_chunks += 2;
        checks++;
        if (timeout || obs_addr.size() != 2 || obs_data.size() != 96) begin
            errors++;
            $display("[TB] FAIL boundary_counts: got to %0d cmds %0d beats %0d, expected 0/2/96",
                     timeout, obs_addr.size(), obs_data.size());
        end
        checks++;
        if (obs_addr.size() == 2 && (obs_addr[0] !== 64'h5800 || obs_len[0] !== 32'd2048 ||
                                     obs_addr[1] !== 64'h6000 || obs_len[1] !== 32'd4096)) begin
            errors++;
            $display("[TB] FAIL boundary_cmds: got (%0h,%0d)(%0h,%0d), expected (5800,2048)(6000,4096)",
                     obs_addr[0], obs_len[0], obs_addr[1], obs_len[1]);
        end
    endtask

    task automatic test_backpressure();
        fill_stream(1, 1'b0);
        run_cmd(64'h0, 32'd64, 10, 40, 100);
        exp_chunks += 1;
        checks++;
        if (timeout || obs_wait.size() != 1 || cmd_unstable != 0) begin
            errors++;
            $display("[TB] FAIL bp_cmd: got to %0d cmds %0d unstable %0d, expected 0/1/0", timeout, obs_wait.size(), cmd_unstable);
        end
        checks++;
        if (obs_wait.size() > 0 && obs_wait[0] != 10) begin
            errors++;
            $display("[TB] FAIL bp_hold: got %0d stalled cycles, expected 10", obs_wait[0]);
        end
        checks++;
        if (obs_data.size() != 1 || obs_last.size() != 1 || obs_last[0] !== 1'b1 || obs_data[0] !== up_data[0]) begin
            errors++;
            $display("[TB] FAIL bp_beat: got %0d beats, expected 1 beat with last", obs_data.size());
        end
    endtask

    task automatic test_zero_length();
        fill_stream(0, 1'b0);
        run_cmd(64'h2000, 32'd0, 0, 100, 100);
        exp_errors += 1;
        checks++;
        if (timeout || scmd_cyc < 0) begin
            errors++;
            $display("[TB] FAIL zero_accept: got timeout %0d handshake cycle %0d, expected accepted", timeout, scmd_cyc);
        end
        checks++;
        if (obs_rise.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_no_cmd: got %0d m_cmd_valid rises, expected 0", obs_rise.size());
        end
        checks++;
        if (stat_errors !== (STATS_ON ? exp_errors : 0) || stat_chunks !== (STATS_ON ? exp_chunks : 0)) begin
            errors++;
            $display("[TB] FAIL zero_stats: got %0d/%0d, expected %0d/%0d", stat_chunks, stat_errors,
                     STATS_ON ? exp_chunks : 0, STATS_ON ? exp_errors : 0);
        end
    endtask

    task automatic test_last_mismatch();
        fill_stream(128, 1'b0);
        up_last[127] = 1'b0;
        up_last[63]  = 1'b1;
        run_cmd(64'h0, 32'd8192, 0, 80, 80);
        exp_chunks += 2;
        exp_errors += 2;
        checks++;
        if (timeout || obs_addr.size() != 2 || obs_data.size() != 128) begin
            errors++;
            $display("[TB] FAIL mism_counts: got to %0d cmds %0d beats %0d, expected 0/2/128",
                     timeout, obs_addr.size(), obs_data.size());
        end
        checks++;
        if (obs_addr.size() == 2 && (obs_addr[0] !== 64'h0 || obs_len[0] !== 32'd4096 ||
                                     obs_addr[1] !== 64'h1000 || obs_len[1] !== 32'd4096)) begin
            errors++;
            $display("[TB] FAIL mism_cmds: got (%0h,%0d)(%0h,%0d), expected (0,4096)(1000,4096)",
                     obs_addr[0], obs_len[0], obs_addr[1], obs_len[1]);
        end
        checks++;
        if (obs_last_cyc.size() != 2) begin
            errors++;
            $display("[TB] FAIL mism_lasts: got %0d last beats, expected 2", obs_last_cyc.size());
        end
        checks++;
        if (stat_errors !== (STATS_ON ? exp_errors : 0) || stat_chunks !== (STATS_ON ? exp_chunks : 0)) begin
            errors++;
            $display("[TB] FAIL mism_stats: got %0d/%0d, expected %0d/%0d", stat_chunks, stat_errors,
                     STATS_ON ? exp_chunks : 0, STATS_ON ? exp_errors : 0);
        end
    endtask

    task automatic test_reset_mid_data();
        int n, lasts;
        bit hit, cmd_done;
        fill_stream(64, 1'b0);
        n = 0; lasts = 0; hit = 1'b0; cmd_done = 1'b0;
        s_cmd_address = 64'h4000;
        s_cmd_length  = 32'd4096;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge pcie_clk);
            s_cmd_valid  = !cmd_done;
            m_cmd_ready  = 1'b1;
            m_data_ready = 1'b1;
            if (n == 20) begin
                pcie_rst = 1'b1;
                hit = 1'b1;
            end
            s_data_valid = 1'b1;
            s_data_data  = up_data[n];
            s_data_keep  = up_keep[n];
            s_data_last  = up_last[n];
            #1;
            if (s_cmd_valid && s_cmd_ready) cmd_done = 1'b1;
            if (m_data_last) lasts++;
            if (m_data_valid && m_data_ready && n < 63) n++;
        end
        checks++;
        if (!hit || lasts != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_reach: got reached %0d lasts %0d, expected 1/0", hit, lasts);
        end
        @(negedge pcie_clk);
        idle_inputs();
        #1;
        checks++;
        if ({s_cmd_ready, m_cmd_valid, m_data_valid, m_data_last, s_data_ready} !== 5'b0 ||
            {m_cmd_address, m_cmd_length, stat_chunks, stat_errors} !== 160'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got ctrl %b addr %0h len %0d stats %0d/%0d, expected all 0",
                     {s_cmd_ready, m_cmd_valid, m_data_valid, m_data_last, s_data_ready},
                     m_cmd_address, m_cmd_length, stat_chunks, stat_errors);
        end
        @(negedge pcie_clk);
        pcie_rst = 1'b0;
        #1;
        checks++;
        if (s_cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_ready: got %b, expected 1", s_cmd_ready);
        end
        exp_chunks = 0;
        exp_errors = 0;
        fill_stream(1, 1'b0);
        run_cmd(64'h3000, 32'd64, 0, 100, 100);
        exp_chunks += 1;
        checks++;
        if (timeout || obs_addr.size() != 1 || obs_data.size() != 1 || obs_last[0] !== 1'b1 ||
            obs_addr[0] !== 64'h3000 || obs_len[0] !== 32'd64) begin
            errors++;
            $display("[TB] FAIL rstmid_followup: got to %0d cmds %0d beats %0d, expected one (3000,64) with last",
                     timeout, obs_addr.size(), obs_data.size());
        end
        checks++;
        if (stat_chunks !== (STATS_ON ? exp_chunks : 0) || stat_errors !== (STATS_ON ? exp_errors : 0)) begin
            errors++;
            $display("[TB] FAIL rstmid_stats: got %0d/%0d, expected %0d/%0d", stat_chunks, stat_errors,
                     STATS_ON ? exp_chunks : 0, STATS_ON ? exp_errors : 0);
        end
    endtask

    task automatic test_random();
        logic [63:0] addr;
        logic [31:0] len;
        int total;
        for (int it = 0; it < 8; it++) begin
            addr  = {$urandom, $urandom} & ~64'h3F;
            len   = 32'($urandom_range(1, 160)) << 6;
            total = int'(len >> 6);
            fill_stream(total, 1'b0);
            for (int i = 0; i < total; i++) if ($urandom_range(19) == 0) up_last[i] = !up_last[i];
            run_cmd(addr, len, $urandom_range(3), $urandom_range(50, 100), $urandom_range(50, 100));
            model_split(addr, len);
            checks++;
            if (timeout || obs_addr.size() != exp_addr.size() || obs_data.size() != total ||
                cmd_unstable != 0 || pass_err != 0 || stray_last != 0) begin
                errors++;
                $display("[TB] FAIL rnd%0d_counts: got to %0d cmds %0d beats %0d unst %0d pass %0d stray %0d, expected 0/%0d/%0d/0/0/0",
                         it, timeout, obs_addr.size(), obs_data.size(), cmd_unstable, pass_err, stray_last,
                         exp_addr.size(), total);
            end
            for (int k = 0; k < obs_addr.size() && k < exp_addr.size(); k++) begin
                checks++;
                if (obs_addr[k] !== exp_addr[k] || obs_len[k] !== exp_len[k]) begin
                    errors++;
                    $display("[TB] FAIL rnd%0d_cmd%0d: got (%0h,%0d), expected (%0h,%0d)",
                             it, k, obs_addr[k], obs_len[k], exp_addr[k], exp_len[k]);
                end
            end
            for (int i = 0; i < obs_data.size() && i < total; i++) begin
                checks++;
                if (obs_data[i] !== up_data[i] || obs_keep[i] !== up_keep[i] || obs_last[i] !== exp_last[i]) begin
                    errors++;
                    $display("[TB] FAIL rnd%0d_beat%0d: got last %0d keep %0h, expected last %0d keep %0h (data match %0d)",
                             it, i, obs_last[i], obs_keep[i], exp_last[i], up_keep[i], obs_data[i] === up_data[i]);
                end
            end
            checks++;
            if (obs_rise.size() < 1 || obs_rise[0] != scmd_cyc + 2) begin
                errors++;
                $display("[TB] FAIL rnd%0d_latency: got rise %0d, expected %0d",
                         it, obs_rise.size() ? obs_rise[0] : -1, scmd_cyc + 2);
            end
            for (int k = 1; k < obs_rise.size() && k - 1 < obs_last_cyc.size(); k++) begin
                checks++;
                if (obs_rise[k] != obs_last_cyc[k-1] + 2) begin
                    errors++;
                    $display("[TB] FAIL rnd%0d_gap%0d: got rise %0d, expected %0d", it, k, obs_rise[k], obs_last_cyc[k-1] + 2);
                end
            end
            checks++;
            if (stat_chunks !== (STATS_ON ? exp_chunks : 0) || stat_errors !== (STATS_ON ? exp_errors : 0)) begin
                errors++;
                $display("[TB] FAIL rnd%0d_stats: got %0d/%0d, expected %0d/%0d", it, stat_chunks, stat_errors,
                         STATS_ON ? exp_chunks : 0, STATS_ON ? exp_errors : 0);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        exp_chunks = 0;
        exp_errors = 0;
        test_reset();
        test_aligned();
        test_unaligned();
        test_boundary();
        test_backpressure();
        test_zero_length();
        test_last_mismatch();
        test_reset_mid_data();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_wr_splitter.md
# dma_wr_splitter

Write-path stage between the DMA test generator and `dma_inf`'s `s_axis_dma_write_cmd` / `s_axis_dma_write_data` channel 0. It accepts one write command of arbitrary 64 B-multiple length and re-issues it as a sequence of sub-commands that never cross a `MAX_LEN`-aligned address boundary. It forwards the 512-bit data stream and regenerates `last` at every sub-command boundary, so the XDMA engine only ever sees page-contained transfers.

## Interface
- `MAX_LEN`, 4096: maximum sub-command length and alignment boundary in bytes; power of two, range 64..65536.
- `pcie_clk`  in  1  clock for all logic.
- `pcie_rst`  in  1  synchronous reset, active-high.
- `s_cmd_valid` / `s_cmd_ready`  in / out  1  upstream command handshake.
- `s_cmd_address`  in  64  byte address; bits [5:0] are zero.
- `s_cmd_length`  in  32  byte length; bits [5:0] are zero.
- `m_cmd_valid` / `m_cmd_ready`  out / in  1  sub-command handshake to `dma_inf`.
- `m_cmd_address`  out  64  sub-command address.
- `m_cmd_length`  out  32  sub-command length.
- `s_data_valid` / `s_data_ready`  in / out  1  upstream data handshake.
- `s_data_data`  in  512  data beat.
- `s_data_keep`  in  64  byte enables.
- `s_data_last`  in  1  upstream end of transfer; used only for the consistency check.
- `m_data_valid` / `m_data_ready`  out / in  1  downstream data handshake.
- `m_data_data` / `m_data_keep`  out  512 / 64  beat passthrough.
- `m_data_last`  out  1  last beat of the current sub-command.
- `stat_chunks`  out  32  sub-commands issued.
- `stat_errors`  out  32  protocol errors counted.

## Operation
- FSM with states IDLE, CALC, CMD and DATA.
- IDLE:
  - `s_cmd_ready`=1.
  - On handshake, latch `cur_addr`←address and `rem`←length.
  - Length 0: no sub-command is issued, `stat_errors`+1, stay in IDLE.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - `room` = MAX_LEN − (`cur_addr` & (MAX_LEN−1)).
  - `chunk` = min(`rem`, `room`), 32-bit unsigned.
  - `beats` = `chunk`>>6.
  - Register `m_cmd_address`←`cur_addr` and `m_cmd_length`←`chunk`.
  - Go to CMD.
- CMD:
  - `m_cmd_valid`=1; fields are held stable until handshake.
  - On handshake: `cur_addr`+=`chunk`, `rem`−=`chunk`, `beat_cnt`←0, go to DATA.
- DATA:
  - Combinational passthrough: `m_data_valid`=`s_data_valid`, `s_data_ready`=`m_data_ready`, data and keep forwarded unchanged.
  - `m_data_last` = (`beat_cnt`==`beats`−1) & `m_data_valid`.
  - Each beat handshake increments `beat_cnt`.
  - On the last-beat handshake: go to IDLE if `rem`==0, else go to CALC.
- Outside DATA: `s_data_ready`=0 and `m_data_valid`=0.
- Consistency check, on each DATA handshake; each violating beat adds 1 to `stat_errors`, and data is forwarded unchanged:
  - `s_data_last`=1 on a beat that is not the final beat of the final sub-command is an error.
  - `s_data_last`=0 on the final beat of the final sub-command is an error.
- `stat_chunks` increments on every `m_cmd` handshake.
- Both counters wrap at 2^32.

## Timing
- Reset values:
  - State is IDLE.
  - Outputs `m_cmd_valid`, `m_data_valid`, `m_data_last`, `s_data_ready` are 0; `s_cmd_ready` is 0 during reset.
  - `m_cmd_address`, `m_cmd_length`, `cur_addr`, `rem`, `beat_cnt`, `stat_*` are 0.
- `s_cmd_ready` rises in the first cycle after `pcie_rst` deasserts.
- Latency:
  - `s_cmd` handshake at cycle T gives `m_cmd_valid`=1 at T+2.
  - A sub-command's final-beat handshake at cycle U gives the next `m_cmd_valid` at U+2.
  - Data path adds zero cycles of latency.
- A new `s_cmd` is accepted only in IDLE, at most one cycle after the final beat of the previous command.
- `m_cmd_valid` does not drop, and its fields do not change, before `m_cmd_ready`.
- Reset asserted mid-CMD or mid-DATA:
  - Outputs return to reset values on the next edge.
  - The partially sent transfer is abandoned.
  - No `m_data_last` is generated for it.
- Lengths reaching exactly `room` end on the boundary; the next chunk starts at offset 0 with `room`=MAX_LEN.

## Configuration
- `DMA_SPLIT_STATS_EN` defined:
  - `stat_chunks` and `stat_errors` counters are implemented as described.
- `DMA_SPLIT_STATS_EN` not defined:
  - Both counters are removed and both ports are tied to 32'h0.
  - The length-0 command is still consumed without issuing anything.
  - All other behaviour is identical.

## Test plan
- Aligned single chunk, address 0x1000, length 4096, `s_data_last` on beat 63:
  - One `m_cmd` (0x1000, 4096); 64 beats; `m_data_last` only on beat 63.
  - `stat_chunks`=1, `stat_errors`=0.
- Unaligned span, address 0x1_0000_0F00, length 8192, upstream data is an incrementing counter:
  - Sub-commands (0x1_0000_0F00, 256), (0x1_0000_1000, 4096), (0x1_0000_2000, 3840).
  - `m_data_last` on beats 3, 67 and 127.
  - Data is unchanged.
- Backpressure, address 0x0, length 64, `m_cmd_ready` held 0 for 10 cycles:
  - `m_cmd_valid` is held with stable fields for 10 cycles.
  - A single beat follows, with `m_data_last`=1.
  - Random `m_data_ready` gaps neither drop nor duplicate beats.
- Zero length, address 0x2000, length 0:
  - `s_cmd_ready` handshake completes with no `m_cmd_valid`.
  - `stat_errors`=1 with the macro defined, 0 with it undefined.
- Upstream last mismatch, address 0x0, length 8192 with `s_data_last` on beat 63:
  - Two sub-commands are issued normally.
  - `stat_errors`=2: one for the early last, one for the missing last on beat 127.
- Reset mid-DATA, `pcie_rst` pulsed during beat 20 of 4096 B:
  - All outputs return to reset values the next cycle.
  - `s_cmd_ready`=1 one cycle after release.
  - A following 64 B command completes normally.
